// File: rtl/dmem_slave.sv
// Data-memory responder: byte-lane-writable word RAM with combinational read, plus an
// optional memory-mapped timer window at 0x1000_0000 enabled by defining DMEM_MMIO_EN.
module dmem_slave #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [3:0]  sel_i,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic        irq_o
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]           r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] w_wordIdx;
   logic                  w_mmioHit;
   logic                  w_ramWe;
   logic [31:0]           w_ramRdata;
   logic [31:0]           w_mmioRdata;
   logic                  w_unusedAddr;

   // Upper address bits alias onto the RAM; byte offset is resolved by the core.
   assign w_wordIdx    = addr_i[DEPTH_LOG2+1:2];
   assign w_unusedAddr = ^{addr_i[1:0], addr_i[31:DEPTH_LOG2+2]};
   assign w_ramRdata   = r_mem[w_wordIdx];
   assign w_ramWe      = ce_i & we_i & ~w_mmioHit;

   always_ff @(posedge clk) begin
      if (!rst && w_ramWe) begin
         for (int i = 0; i < 4; i++) begin
            if (sel_i[i]) begin
               r_mem[w_wordIdx][8*i +: 8] <= data_i[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      data_o = '0;
      if (ce_i && !we_i) begin
         data_o = w_mmioHit ? w_mmioRdata : w_ramRdata;
      end
   end

`ifdef DMEM_MMIO_EN
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic        r_pend;
   logic        r_en;
   logic        r_ie;
   logic        r_irq;
   logic        w_mmioWr;
   logic        w_wrCount;
   logic        w_wrCompare;
   logic        w_wrStatus;
   logic        w_wrCtrl;
   logic        w_match;

   assign w_mmioHit   = (addr_i[31:4] == 28'h1000000);
   assign w_mmioWr    = ce_i & we_i & w_mmioHit & (sel_i == 4'b1111);
   assign w_wrCount   = w_mmioWr & (addr_i[3:2] == 2'd0);
   assign w_wrCompare = w_mmioWr & (addr_i[3:2] == 2'd1);
   assign w_wrStatus  = w_mmioWr & (addr_i[3:2] == 2'd2);
   assign w_wrCtrl    = w_mmioWr & (addr_i[3:2] == 2'd3);
   assign w_match     = r_en & (r_count == r_compare);

   // Software writes to COUNT override the increment; a match beats a W1C clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count   <= 32'h0;
         r_compare <= 32'hFFFF_FFFF;
         r_pend    <= 1'b0;
         r_en      <= 1'b0;
         r_ie      <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         r_irq <= r_pend & r_ie;
         if (w_wrCount) begin
            r_count <= data_i;
         end else if (r_en) begin
            r_count <= r_count + 32'd1;
         end
         if (w_match) begin
            r_pend <= 1'b1;
         end else if (w_wrStatus && data_i[0]) begin
            r_pend <= 1'b0;
         end
         if (w_wrCompare) begin
            r_compare <= data_i;
         end
         if (w_wrCtrl) begin
            r_en <= data_i[0];
            r_ie <= data_i[1];
         end
      end
   end

   always_comb begin
      w_mmioRdata = '0;
      case (addr_i[3:2])
         2'd0:    w_mmioRdata = r_count;
         2'd1:    w_mmioRdata = r_compare;
         2'd2:    w_mmioRdata = {31'h0, r_pend};
         default: w_mmioRdata = {30'h0, r_ie, r_en};
      endcase
   end

   assign irq_o = r_irq;
`else
   assign w_mmioHit   = 1'b0;
   assign w_mmioRdata = '0;
   assign irq_o       = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_slave.sv
// Directed bench for dmem_slave: RAM lanes, aliasing, reset behaviour, and either the
// timer window (DMEM_MMIO_EN defined) or plain RAM decoding of the MMIO range.
module tb_dmem_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ceI = 1'b0;
   logic        weI = 1'b0;
   logic [31:0] addrI = '0;
   logic [3:0]  selI = '0;
   logic [31:0] dataI = '0;
   logic [31:0] dataO;
   logic        irqO;

   int testCount = 0;
   int failCount = 0;

   localparam logic [31:0] A_COUNT   = 32'h1000_0000;
   localparam logic [31:0] A_COMPARE = 32'h1000_0004;
   localparam logic [31:0] A_STATUS  = 32'h1000_0008;
   localparam logic [31:0] A_CTRL    = 32'h1000_000C;

   dmem_slave #(.DEPTH_LOG2(10)) dut (
      .clk    (clk),
      .rst    (rst),
      .ce_i   (ceI),
      .we_i   (weI),
      .addr_i (addrI),
      .sel_i  (selI),
      .data_i (dataI),
      .data_o (dataO),
      .irq_o  (irqO)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drives one write cycle; returns 1 ns after the capturing edge.
   task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
      ceI = 1'b1; weI = 1'b1; addrI = addr; dataI = data; selI = sel;
      @(posedge clk); #1;
      ceI = 1'b0; weI = 1'b0; selI = '0;
   endtask

   task automatic readWord(input logic [31:0] addr, output logic [31:0] data);
      ceI = 1'b1; weI = 1'b0; addrI = addr; selI = 4'b0000;
      #1;
      data = dataO;
      ceI = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   logic [31:0] rd;

   initial begin
      rst = 1'b1;
      tick(2);
      rst = 1'b0;

      // Byte lanes, idle value, and write-enable idle value
      applyStimulus(32'h0000_0010, 32'h1122_3344, 4'b1111);
      applyStimulus(32'h0000_0010, 32'h00AA_0000, 4'b0100);
      readWord(32'h0000_0010, rd);
      checkOutput("lane_merge", rd, 32'h11AA_3344);
      ceI = 1'b0; addrI = 32'h0000_0010; #1;
      checkOutput("idle_ce0", dataO, 32'h0);
      ceI = 1'b1; weI = 1'b1; selI = 4'b0000; #1;
      checkOutput("idle_we1", dataO, 32'h0);
      @(posedge clk); #1;
      ceI = 1'b0; weI = 1'b0;
      readWord(32'h0000_0010, rd);
      checkOutput("sel0_no_write", rd, 32'h11AA_3344);

      // Aliasing and read-after-write in the following cycle
      applyStimulus(32'h0000_1010, 32'hDEAD_BEEF, 4'b1111);
      readWord(32'h0000_0010, rd);
      checkOutput("alias_raw", rd, 32'hDEAD_BEEF);
      applyStimulus(32'h0000_0023, 32'h0102_0304, 4'b1111);
      readWord(32'h0000_0020, rd);
      checkOutput("low_addr_bits", rd, 32'h0102_0304);

      // RAM write on a reset edge is suppressed
      rst = 1'b1;
      applyStimulus(32'h0000_0020, 32'hFFFF_FFFF, 4'b1111);
      rst = 1'b0;
      readWord(32'h0000_0020, rd);
      checkOutput("ram_reset_suppress", rd, 32'h0102_0304);
      checkOutput("irq_after_reset", {31'h0, irqO}, 32'h0);

`ifdef DMEM_MMIO_EN
      readWord(A_COMPARE, rd);
      checkOutput("compare_reset", rd, 32'hFFFF_FFFF);
      readWord(A_CTRL, rd);
      checkOutput("ctrl_reset", rd, 32'h0);
      readWord(A_COUNT, rd);
      checkOutput("count_reset", rd, 32'h0);

      // Match at COUNT==5, irq one edge later, W1C clear then irq drop
      applyStimulus(A_COUNT, 32'h0, 4'b1111);
      applyStimulus(A_COMPARE, 32'h5, 4'b1111);
      applyStimulus(A_CTRL, 32'h3, 4'b1111);
      tick(5);
      readWord(A_COUNT, rd);
      checkOutput("count_at_5", rd, 32'h5);
      readWord(A_STATUS, rd);
      checkOutput("pend_before_match", rd, 32'h0);
      tick(1);
      readWord(A_STATUS, rd);
      checkOutput("pend_after_match", rd, 32'h1);
      checkOutput("irq_not_yet", {31'h0, irqO}, 32'h0);
      tick(1);
      checkOutput("irq_rise", {31'h0, irqO}, 32'h1);
      applyStimulus(A_STATUS, 32'h1, 4'b1111);
      readWord(A_STATUS, rd);
      checkOutput("pend_cleared", rd, 32'h0);
      checkOutput("irq_held_after_clear", {31'h0, irqO}, 32'h1);
      tick(1);
      checkOutput("irq_fall", {31'h0, irqO}, 32'h0);

      // Clear on the same edge as a match: set wins
      applyStimulus(A_COMPARE, 32'h40, 4'b1111);
      applyStimulus(A_COUNT, 32'h40, 4'b1111);
      applyStimulus(A_STATUS, 32'h1, 4'b1111);
      readWord(A_STATUS, rd);
      checkOutput("set_beats_clear", rd, 32'h1);
      readWord(A_COUNT, rd);
      checkOutput("count_after_collision", rd, 32'h41);
      applyStimulus(A_STATUS, 32'h1, 4'b1111);
      applyStimulus(A_CTRL, 32'h1, 4'b1111);

      // Masked interrupt: pend sets, irq stays low
      applyStimulus(A_COMPARE, 32'h82, 4'b1111);
      applyStimulus(A_COUNT, 32'h80, 4'b1111);
      tick(2);
      readWord(A_STATUS, rd);
      checkOutput("masked_pend_before", rd, 32'h0);
      tick(1);
      readWord(A_STATUS, rd);
      checkOutput("masked_pend_set", rd, 32'h1);
      checkOutput("masked_irq_a", {31'h0, irqO}, 32'h0);
      tick(1);
      checkOutput("masked_irq_b", {31'h0, irqO}, 32'h0);
      applyStimulus(A_CTRL, 32'h3, 4'b0011);
      readWord(A_CTRL, rd);
      checkOutput("ctrl_partial_ignored", rd, 32'h1);

      // Reset mid-count with irq high and a simultaneous COUNT write
      applyStimulus(A_CTRL, 32'h3, 4'b1111);
      applyStimulus(A_COUNT, 32'h1234, 4'b1111);
      readWord(A_COUNT, rd);
      checkOutput("count_preset", rd, 32'h1234);
      checkOutput("irq_before_reset", {31'h0, irqO}, 32'h1);
      rst = 1'b1;
      applyStimulus(A_COUNT, 32'h5555, 4'b1111);
      rst = 1'b0;
      readWord(A_COUNT, rd);
      checkOutput("count_after_rst", rd, 32'h0);
      checkOutput("irq_after_rst", {31'h0, irqO}, 32'h0);
      readWord(A_CTRL, rd);
      checkOutput("ctrl_after_rst", rd, 32'h0);
      readWord(A_COMPARE, rd);
      checkOutput("compare_after_rst", rd, 32'hFFFF_FFFF);
      tick(3);
      readWord(A_COUNT, rd);
      checkOutput("count_holds", rd, 32'h0);
`else
      // MMIO range is ordinary aliased RAM
      applyStimulus(32'h1000_0004, 32'hCAFE_F00D, 4'b1111);
      readWord(32'h0000_0004, rd);
      checkOutput("mmio_alias_ram", rd, 32'hCAFE_F00D);
      readWord(32'h1000_0004, rd);
      checkOutput("mmio_addr_read", rd, 32'hCAFE_F00D);
      applyStimulus(32'h1000_000C, 32'h0000_0003, 4'b1111);
      readWord(32'h0000_000C, rd);
      checkOutput("ctrl_addr_is_ram", rd, 32'h0000_0003);
      applyStimulus(32'h1000_0008, 32'h00C3_0000, 4'b0010);
      readWord(32'h0000_0008, rd);
      checkOutput("partial_at_mmio_range", rd & 32'h0000_FF00, 32'h0);
      tick(20);
      checkOutput("irq_tied_low", {31'h0, irqO}, 32'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
